param_arith_unit: RTL and testbench
===================================

// Module: param_arith_unit
// PURPOSE
//  Parametrised successor of the 4-bit add/sub unit: WIDTH-bit registered ALU with op select,
//  Start/Done handshake, a carry/flag register for multi-word ADC/SBB chains, and an optional
//  multi-cycle shift-add multiplier. Result drives the shared IE_ALU bus, tri-stated unless EnableAlu.
// PARAMETERS
//  WIDTH   4  operand/result width in bits, >=2
//  MUL_EN  1  1: op MUL implemented; 0: MUL is a one-cycle no-op
// PORTS
//  Clock      in   1        single clock, all state updates on rising edge
//  Reset      in   1        synchronous, active-high
//  Start      in   1        request; sampled only in IDLE
//  Op         in   3        000 ADD,001 SUB,010 ADC,011 SBB,100 INC A,101 DEC A,110 CMP,111 MUL
//  OpA        in   WIDTH    operand A (keyboard 1 side)
//  OpB        in   WIDTH    operand B (keyboard 2 side)
//  EnableAlu  in   1        bus drive enable
//  Busy       out  1        high from the cycle after Start is accepted until Done
//  Done       out  1        one-cycle pulse; Result/flags valid from this cycle
//  Result     out  WIDTH    result register (MUL: low half)
//  ResultHi   out  WIDTH    MUL high half; 0 after any non-MUL op
//  IE_ALU     out  WIDTH    Result when EnableAlu=1, else all 'z'
//  Carry,Zero,Neg,Ovf out 1 flag register
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high. Reset wins over Start.
//  Reset (incl. mid-MUL): state IDLE, Result=ResultHi=0, all flags 0, Busy=Done=0; MUL aborted.
//  Operands and Op latched into internal registers on the accepting edge; later input changes ignored.
//  FSM: IDLE -Start-> EXEC (Op!=MUL or MUL_EN=0) | MUL (Op=MUL, MUL_EN=1).
//   EXEC -> DONE after 1 cycle; MUL -> DONE after WIDTH iterations; DONE -> IDLE (Done=1 here).
//  Latency: Start accepted at edge N -> Done high cycle after edge N+2 (ALU); N+WIDTH+2 (MUL).
//  Start while Busy or in DONE: ignored, no queuing. Start may be held; re-accepted in IDLE.
//  Arithmetic (WIDTH+1-bit sum; B side inverted for subtract, as in the original unit):
//   ADD A+B+0; SUB A+~B+1; ADC A+B+C; SBB A+~B+C; INC A+0+1; DEC A+~0+0 (i.e. A-1).
//   Carry = sum[WIDTH] (for SUB/SBB/DEC: 1 = no borrow). Ovf = signed overflow of the add.
//   Zero = (Result==0); Neg = Result[WIDTH-1]. MUL: Zero over {Hi,Lo}, Neg=Hi[MSB],
//   Carry=(Hi!=0), Ovf=0.
//  CMP: computes SUB, updates flags only; Result/ResultHi unchanged.
//  MUL_EN=0 with Op=MUL: Done after EXEC, Result/ResultHi/flags unchanged.
//  MUL: unsigned shift-add, one multiplier bit per cycle, 2*WIDTH product; Result/ResultHi
//   update only at DONE (no partial values visible).
//  Wrap-around: ADD/INC overflow wraps modulo 2^WIDTH, Carry=1. DEC of 0 -> all ones, Carry=0.
//  IE_ALU is combinational from EnableAlu and Result register; independent of FSM state.
// STRUCTURE
//  Package alu_pkg: op_e (3-bit opcodes above), state_e {IDLE,EXEC,MUL,DONE}, flag index consts.
//  Sub-module add_sub_core #(WIDTH): combinational a,b,sub,cin -> sum,cout,ovf; used by EXEC and
//  reused by the MUL partial-sum accumulate step.
// TESTING
//  Reset: pulse Reset mid-MUL (WIDTH=4, 15*15) -> next cycle Busy=0, Result=0, flags 0, no Done.
//  ADD chain: 0xF+0x1 -> Result=0x0, Carry=1, Zero=1; then ADC 0x0+0x0 -> Result=0x1, Carry=0.
//  SUB: 0x3-0x5 -> Result=0xE, Carry=0, Neg=1; 0x8-0x1 -> Result=0x7, Ovf=1; CMP 5,5 -> Zero=1, Result held.
//  MUL WIDTH=4: 0xD*0xB -> {ResultHi,Result}=0x8F, Done exactly 6 cycles after accepting edge,
//   Carry=1; Start pulses while Busy ignored.
//  Bus: EnableAlu=0 -> IE_ALU all z; EnableAlu=1 -> IE_ALU==Result in same cycle.
//  Param sweep WIDTH=8, MUL_EN=0: random ADD/SUB/INC/DEC vs reference model; MUL -> 1-cycle no-op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the arithmetic unit.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_ADC = 3'b010,
      OP_SBB = 3'b011,
      OP_INC = 3'b100,
      OP_DEC = 3'b101,
      OP_CMP = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Bit positions inside the flag register.
   localparam int FLAG_C    = 0;
   localparam int FLAG_Z    = 1;
   localparam int FLAG_N    = 2;
   localparam int FLAG_V    = 3;
   localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/add_sub_core.sv
// Combinational WIDTH-bit adder with optional B inversion; the subtract
// path is A + ~B + cin, so carry-out 1 means "no borrow".
module add_sub_core #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   full;

   // One WIDTH+1-bit add; signed overflow when both addends share a sign the sum lacks.
   always_comb begin
      b_eff = sub ? ~b : b;
      full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      sum   = full[WIDTH-1:0];
      cout  = full[WIDTH];
      ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

endmodule

// File: rtl/param_arith_unit.sv
// Registered WIDTH-bit ALU with Start/Done handshake, flag register for
// multi-word ADC/SBB chains and an optional shift-add multiplier.
//
// Handshake: Start is sampled only while the FSM is IDLE; the accepting edge
// latches Op/OpA/OpB. Busy is high while the FSM is outside IDLE. Done is a
// one-cycle pulse raised in the cycle after DONE, and Result/ResultHi/flags
// hold the new values from that same cycle. Start outside IDLE is dropped.
module param_arith_unit
   import alu_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   input  logic             EnableAlu,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] ResultHi,
   output logic [WIDTH-1:0] IE_ALU,
   output logic             Carry,
   output logic             Zero,
   output logic             Neg,
   output logic             Ovf,
   output logic [1:0]       dbg_state
);

   localparam int             CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

   state_e                 state_q, state_d;
   op_e                    op_q;
   logic [WIDTH-1:0]       a_q, b_q;
   logic [WIDTH-1:0]       acc_hi_q, acc_lo_q;
   logic [CW-1:0]          cnt_q;
   logic [WIDTH-1:0]       pend_res_q, pend_hi_q;
   logic [NUM_FLAGS-1:0]   pend_flags_q;
   logic                   upd_res_q, upd_flags_q;
   logic [WIDTH-1:0]       result_q, result_hi_q;
   logic [NUM_FLAGS-1:0]   flags_q;
   logic                   done_q;

   logic [WIDTH-1:0]       core_a, core_b, core_sum;
   logic                   core_sub, core_cin, core_cout, core_ovf;
   logic [NUM_FLAGS-1:0]   exec_flags, mul_flags;

   add_sub_core #(.WIDTH(WIDTH)) u_core (
      .a    (core_a),
      .b    (core_b),
      .sub  (core_sub),
      .cin  (core_cin),
      .sum  (core_sum),
      .cout (core_cout),
      .ovf  (core_ovf)
   );

   // Steer the shared adder: latched operands in EXEC, accumulator + A during MUL.
   always_comb begin
      core_a   = a_q;
      core_b   = b_q;
      core_sub = 1'b0;
      core_cin = 1'b0;
      if (state_q == ST_MUL) begin
         core_a = acc_hi_q;
         core_b = a_q;
      end else begin
         case (op_q)
            OP_SUB, OP_CMP: begin
               core_sub = 1'b1;
               core_cin = 1'b1;
            end
            OP_ADC: core_cin = flags_q[FLAG_C];
            OP_SBB: begin
               core_sub = 1'b1;
               core_cin = flags_q[FLAG_C];
            end
            OP_INC: begin
               core_b   = '0;
               core_cin = 1'b1;
            end
            OP_DEC: begin
               core_b   = '0;
               core_sub = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Flag vectors for the ALU result and for the finished 2*WIDTH product.
   always_comb begin
      exec_flags         = '0;
      exec_flags[FLAG_C] = core_cout;
      exec_flags[FLAG_Z] = (core_sum == '0);
      exec_flags[FLAG_N] = core_sum[WIDTH-1];
      exec_flags[FLAG_V] = core_ovf;
      mul_flags          = '0;
      mul_flags[FLAG_C]  = |acc_hi_q;
      mul_flags[FLAG_Z]  = ~|{acc_hi_q, acc_lo_q};
      mul_flags[FLAG_N]  = acc_hi_q[WIDTH-1];
   end

   // Next-state logic; MUL stays until the iteration counter reaches WIDTH.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               if ((op_e'(Op) == OP_MUL) && MUL_EN) state_d = ST_MUL;
               else                                 state_d = ST_EXEC;
            end
         end
         ST_EXEC: state_d = ST_DONE;
         ST_MUL:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset wins over everything, including a running MUL.
   always_ff @(posedge Clock) begin
      if (Reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Datapath: latch on accept, compute into pending registers, commit in DONE.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         op_q         <= OP_ADD;
         a_q          <= '0;
         b_q          <= '0;
         acc_hi_q     <= '0;
         acc_lo_q     <= '0;
         cnt_q        <= '0;
         pend_res_q   <= '0;
         pend_hi_q    <= '0;
         pend_flags_q <= '0;
         upd_res_q    <= 1'b0;
         upd_flags_q  <= 1'b0;
         result_q     <= '0;
         result_hi_q  <= '0;
         flags_q      <= '0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (Start) begin
                  op_q     <= op_e'(Op);
                  a_q      <= OpA;
                  b_q      <= OpB;
                  acc_hi_q <= '0;
                  acc_lo_q <= OpB;
                  cnt_q    <= '0;
               end
            end
            ST_EXEC: begin
               pend_res_q   <= core_sum;
               pend_hi_q    <= '0;
               pend_flags_q <= exec_flags;
               upd_res_q    <= (op_q != OP_CMP) && (op_q != OP_MUL);
               upd_flags_q  <= (op_q != OP_MUL);
            end
            ST_MUL: begin
               if (cnt_q != CNT_LAST) begin
                  // Add A when the current multiplier bit is set, then shift the pair right.
                  if (acc_lo_q[0]) {acc_hi_q, acc_lo_q} <= {core_cout, core_sum, acc_lo_q[WIDTH-1:1]};
                  else             {acc_hi_q, acc_lo_q} <= {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
                  cnt_q <= cnt_q + CW'(1);
               end else begin
                  pend_res_q   <= acc_lo_q;
                  pend_hi_q    <= acc_hi_q;
                  pend_flags_q <= mul_flags;
                  upd_res_q    <= 1'b1;
                  upd_flags_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               if (upd_res_q) begin
                  result_q    <= pend_res_q;
                  result_hi_q <= pend_hi_q;
               end
               if (upd_flags_q) flags_q <= pend_flags_q;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign Busy      = (state_q != ST_IDLE);
   assign Done      = done_q;
   assign Result    = result_q;
   assign ResultHi  = result_hi_q;
   assign Carry     = flags_q[FLAG_C];
   assign Zero      = flags_q[FLAG_Z];
   assign Neg       = flags_q[FLAG_N];
   assign Ovf       = flags_q[FLAG_V];
   assign dbg_state = state_q;
   assign IE_ALU    = EnableAlu ? result_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_param_arith_unit.sv
// Bench for param_arith_unit: a WIDTH=4 multiplier-enabled instance with
// hand-computed vectors and a WIDTH=8 MUL_EN=0 instance checked against an
// integer reference model.
module tb_param_arith_unit;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, ADC = 3'b010, SBB = 3'b011;
   localparam logic [2:0] INC = 3'b100, DEC = 3'b101, CMP = 3'b110, MUL = 3'b111;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic       start4, en4, busy4, done4, c4, z4, n4, v4;
   logic [2:0] op4;
   logic [3:0] a4, b4, res4, hi4;
   wire  [3:0] bus4;
   logic [1:0] st4;

   logic       start8, en8, busy8, done8, c8, z8, n8, v8;
   logic [2:0] op8;
   logic [7:0] a8, b8, res8, hi8;
   wire  [7:0] bus8;
   logic [1:0] st8;

   param_arith_unit #(.WIDTH(4), .MUL_EN(1'b1)) dut4 (
      .Clock(clk), .Reset(rst), .Start(start4), .Op(op4), .OpA(a4), .OpB(b4),
      .EnableAlu(en4), .Busy(busy4), .Done(done4), .Result(res4), .ResultHi(hi4),
      .IE_ALU(bus4), .Carry(c4), .Zero(z4), .Neg(n4), .Ovf(v4), .dbg_state(st4)
   );

   param_arith_unit #(.WIDTH(8), .MUL_EN(1'b0)) dut8 (
      .Clock(clk), .Reset(rst), .Start(start8), .Op(op8), .OpA(a8), .OpB(b8),
      .EnableAlu(en8), .Busy(busy8), .Done(done8), .Result(res8), .ResultHi(hi8),
      .IE_ALU(bus8), .Carry(c8), .Zero(z8), .Neg(n8), .Ovf(v8), .dbg_state(st8)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [15:0] exp4_q[$];   // {latency[3:0], hi[3:0], res[3:0], {V,N,Z,C}}
   logic [23:0] exp8_q[$];   // {latency[3:0], hi[7:0], res[7:0], {V,N,Z,C}}
   int acc4 = 0, acc8 = 0;
   int done4_cnt = 0, done8_cnt = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Monitor for the WIDTH=4 instance: pop on every Done pulse.
   always @(negedge clk) begin
      if (done4 === 1'b1) begin
         done4_cnt++;
         if (exp4_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut4_extra_done got=done exp=none (t=%0t)", $time);
         end else begin
            check("dut4_result", {4'(cyc - acc4), hi4, res4, v4, n4, z4, c4}, exp4_q.pop_front());
         end
      end
   end

   // Monitor for the WIDTH=8 instance.
   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         done8_cnt++;
         if (exp8_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut8_extra_done got=done exp=none (t=%0t)", $time);
         end else begin
            check("dut8_result", {4'(cyc - acc8), hi8, res8, v8, n8, z8, c8}, exp8_q.pop_front());
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic start4_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      int n = 0;
      while (st4 !== 2'd0 && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) begin total++; bad++; $display("FAIL dut4_idle_wait got=busy exp=idle"); end
      start4 = 1'b1; op4 = op; a4 = a; b4 = b;
      @(negedge clk);
      acc4   = cyc;
      start4 = 1'b0;
   endtask

   task automatic wait4();
      int n = 0;
      int seen = done4_cnt;
      while (done4_cnt == seen && n < 30) begin @(negedge clk); n++; end
      if (n >= 30) begin total++; bad++; $display("FAIL dut4_done_timeout got=none exp=done"); end
   endtask

   task automatic do4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] e_hi, input logic [3:0] e_res, input logic [3:0] e_flg,
                      input logic [3:0] lat);
      exp4_q.push_back({lat, e_hi, e_res, e_flg});
      start4_op(op, a, b);
      wait4();
   endtask

   task automatic do8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] e_res, input logic [3:0] e_flg);
      int n = 0;
      int seen;
      exp8_q.push_back({4'd2, 8'h00, e_res, e_flg});
      while (st8 !== 2'd0 && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) begin total++; bad++; $display("FAIL dut8_idle_wait got=busy exp=idle"); end
      start8 = 1'b1; op8 = op; a8 = a; b8 = b;
      @(negedge clk);
      acc8   = cyc;
      start8 = 1'b0;
      seen   = done8_cnt;
      n      = 0;
      while (done8_cnt == seen && n < 30) begin @(negedge clk); n++; end
      if (n >= 30) begin total++; bad++; $display("FAIL dut8_done_timeout got=none exp=done"); end
   endtask

   // Integer reference for the 8-bit ALU: returns {res, V, N, Z, C}.
   function automatic logic [11:0] ref8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int ua, ub, sa, sb, r, s;
      logic [7:0] res;
      logic c, v;
      ua = int'(a);
      ub = (op == INC || op == DEC) ? 1 : int'(b);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      if (op == ADD || op == INC) begin
         r = ua + ub;  s = sa + sb;  c = (r > 255);
      end else begin
         r = ua - ub;  s = sa - sb;  c = (ua >= ub);
      end
      res = 8'(r);
      v   = (s > 127) || (s < -128);
      return {res, v, res[7], (res == 8'h00), c};
   endfunction

   // ---------------- stimulus ----------------
   logic [7:0]  m8_res;
   logic [3:0]  m8_flg;
   logic [11:0] r8;
   logic [2:0]  rop;
   logic [7:0]  ra, rb;
   int          saved;

   initial begin
      rst = 1'b1; start4 = 1'b0; start8 = 1'b0; en4 = 1'b0; en8 = 1'b0;
      op4 = ADD; a4 = '0; b4 = '0; op8 = ADD; a8 = '0; b8 = '0;
      repeat (3) @(negedge clk);
      check("reset4_state", {busy4, done4, hi4, res4, v4, n4, z4, c4}, 0);
      check("reset8_state", {busy8, done8, hi8, res8, v8, n8, z8, c8}, 0);
      rst = 1'b0;
      @(negedge clk);

      // ADD/ADC chain, subtract, compare
      do4(ADD, 4'hF, 4'h1, 4'h0, 4'h0, 4'b0011, 4'd2);
      do4(ADC, 4'h0, 4'h0, 4'h0, 4'h1, 4'b0000, 4'd2);
      do4(SUB, 4'h3, 4'h5, 4'h0, 4'hE, 4'b0100, 4'd2);
      do4(SUB, 4'h8, 4'h1, 4'h0, 4'h7, 4'b1001, 4'd2);

      // Bus: tri-stated when disabled, follows Result in the same cycle when enabled
      en4 = 1'b0; #1;
      check("bus4_off", {31'd0, bus4 === 4'h7}, 0);
      en4 = 1'b1; #1;
      check("bus4_on", {28'd0, bus4}, 32'h7);
      en4 = 1'b0;

      do4(CMP, 4'h5, 4'h5, 4'h0, 4'h7, 4'b0011, 4'd2);

      // MUL 0xD*0xB = 0x8F with Start pulses while busy
      exp4_q.push_back({4'd6, 4'h8, 4'hF, 4'b0101});
      start4_op(MUL, 4'hD, 4'hB);
      check("busy4_in_mul", {31'd0, busy4}, 1);
      start4 = 1'b1; op4 = ADD; a4 = 4'h1; b4 = 4'h1;
      @(negedge clk);
      @(negedge clk);
      start4 = 1'b0;
      wait4();

      do4(INC, 4'hF, 4'h0, 4'h0, 4'h0, 4'b0011, 4'd2);
      do4(DEC, 4'h0, 4'h0, 4'h0, 4'hF, 4'b0100, 4'd2);
      do4(SBB, 4'h7, 4'h2, 4'h0, 4'h4, 4'b0001, 4'd2);
      do4(DEC, 4'h8, 4'h0, 4'h0, 4'h7, 4'b1001, 4'd2);
      do4(INC, 4'h7, 4'h0, 4'h0, 4'h8, 4'b1100, 4'd2);
      do4(MUL, 4'hF, 4'hF, 4'hE, 4'h1, 4'b0101, 4'd6);
      do4(CMP, 4'h3, 4'h5, 4'hE, 4'h1, 4'b0100, 4'd2);

      // Reset in the middle of a 15*15 multiply: no Done, everything cleared
      saved = done4_cnt;
      start4_op(MUL, 4'hF, 4'hF);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("reset4_mid_mul", {busy4, done4, hi4, res4, v4, n4, z4, c4}, 0);
      repeat (10) @(negedge clk);
      check("reset4_no_done", done4_cnt, saved);
      do4(ADD, 4'h1, 4'h1, 4'h0, 4'h2, 4'b0000, 4'd2);

      // WIDTH=8, MUL_EN=0: boundary vectors then random ADD/SUB/INC/DEC
      m8_res = 8'h00; m8_flg = 4'b0000;
      r8 = ref8(ADD, 8'hFF, 8'h01); do8(ADD, 8'hFF, 8'h01, r8[11:4], r8[3:0]); m8_res = r8[11:4]; m8_flg = r8[3:0];
      r8 = ref8(SUB, 8'h00, 8'h01); do8(SUB, 8'h00, 8'h01, r8[11:4], r8[3:0]); m8_res = r8[11:4]; m8_flg = r8[3:0];
      r8 = ref8(INC, 8'h7F, 8'h00); do8(INC, 8'h7F, 8'h00, r8[11:4], r8[3:0]); m8_res = r8[11:4]; m8_flg = r8[3:0];
      r8 = ref8(DEC, 8'h80, 8'h00); do8(DEC, 8'h80, 8'h00, r8[11:4], r8[3:0]); m8_res = r8[11:4]; m8_flg = r8[3:0];
      r8 = ref8(DEC, 8'h00, 8'h00); do8(DEC, 8'h00, 8'h00, r8[11:4], r8[3:0]); m8_res = r8[11:4]; m8_flg = r8[3:0];
      for (int i = 0; i < 10; i++) begin
         case ($urandom_range(0, 3))
            0:       rop = ADD;
            1:       rop = SUB;
            2:       rop = INC;
            default: rop = DEC;
         endcase
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         r8 = ref8(rop, ra, rb);
         do8(rop, ra, rb, r8[11:4], r8[3:0]);
         m8_res = r8[11:4]; m8_flg = r8[3:0];
      end
      // MUL with the multiplier compiled out: one-cycle no-op, state untouched
      do8(MUL, 8'h12, 8'h34, m8_res, m8_flg);

      en8 = 1'b1; #1;
      check("bus8_on", {24'd0, bus8}, {24'd0, m8_res});
      en8 = 1'b0;

      repeat (4) @(negedge clk);
      check("queue4_drained", exp4_q.size(), 0);
      check("queue8_drained", exp8_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

endmodule
